// File: rtl/pingpong_buf_ctrl_if.sv
// pingpong_buf_ctrl_if: producer/consumer handshake and data bus of the ping-pong buffer controller
interface pingpong_buf_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
);
    logic              prod_start;
    logic              prod_grant;
    logic              prod_bank;
    logic              prod_we;
    logic [ADDR_W-1:0] prod_addr;
    logic [DATA_W-1:0] prod_din;
    logic              prod_done;
    logic              cons_start;
    logic              cons_grant;
    logic              cons_bank;
    logic              cons_re;
    logic [ADDR_W-1:0] cons_addr;
    logic [DATA_W-1:0] cons_dout;
    logic              cons_dvalid;
    logic              cons_done;

    modport master (
        output prod_start, prod_we, prod_addr, prod_din, prod_done,
        output cons_start, cons_re, cons_addr, cons_done,
        input  prod_grant, prod_bank, cons_grant, cons_bank, cons_dout, cons_dvalid
    );

    modport slave (
        input  prod_start, prod_we, prod_addr, prod_din, prod_done,
        input  cons_start, cons_re, cons_addr, cons_done,
        output prod_grant, prod_bank, cons_grant, cons_bank, cons_dout, cons_dvalid
    );
endinterface

// File: rtl/pingpong_buf_ctrl.sv
// pingpong_buf_ctrl: two-bank ping-pong buffer controller granting banks to a producer and a consumer layer
module pingpong_buf_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    pingpong_buf_ctrl_if.slave bus,
    output logic              bank0_we,
    output logic              bank1_we,
    output logic [ADDR_W-1:0] bank0_addr_a,
    output logic [ADDR_W-1:0] bank1_addr_a,
    output logic [DATA_W-1:0] bank0_din_a,
    output logic [DATA_W-1:0] bank1_din_a,
    output logic [ADDR_W-1:0] bank0_addr_b,
    output logic [ADDR_W-1:0] bank1_addr_b,
    input  logic [DATA_W-1:0] bank0_dout_b,
    input  logic [DATA_W-1:0] bank1_dout_b,
    output logic [1:0]        bank_full,
    output logic [15:0]       tiles_done,
    output logic              err_access
);
    typedef enum logic {P_IDLE, P_ACTIVE} p_state_t;
    typedef enum logic {C_IDLE, C_ACTIVE} c_state_t;

    localparam logic [1:0] EMPTY   = 2'd0;
    localparam logic [1:0] WRITING = 2'd1;
    localparam logic [1:0] FULL    = 2'd2;
    localparam logic [1:0] READING = 2'd3;

    p_state_t          p_state, p_next;
    c_state_t          c_state, c_next;
    logic [1:0]        bst [2];
    logic              wr_ptr, rd_ptr;
    logic              p_grant, c_grant;
    logic              p_take, p_rel, c_take, c_rel, err_now;
    logic [RD_LAT-1:0] vld_sr, sel_sr;
    logic [DATA_W-1:0] dout_q;
    logic              dvalid_q;

    // Grants are decided from registered bank state only, so a release and a
    // new grant on the same bank are always at least one cycle apart.
    assign p_take  = p_state == P_IDLE && bus.prod_start && bst[wr_ptr] == EMPTY;
    assign p_rel   = p_state == P_ACTIVE && bus.prod_done;
    assign c_take  = c_state == C_IDLE && bus.cons_start && bst[rd_ptr] == FULL;
    assign c_rel   = c_state == C_ACTIVE && bus.cons_done;
    assign err_now = ((bus.prod_we | bus.prod_done) & ~p_grant) |
                     ((bus.cons_re | bus.cons_done) & ~c_grant);

    // FSM state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_state <= P_IDLE;
            c_state <= C_IDLE;
        end else begin
            p_state <= p_next;
            c_state <= c_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        p_next = p_take ? P_ACTIVE : p_rel ? P_IDLE : p_state;
        c_next = c_take ? C_ACTIVE : c_rel ? C_IDLE : c_state;
    end

    // FSM outputs: grants follow the registered states
    always_comb begin
        p_grant = p_state == P_ACTIVE;
        c_grant = c_state == C_ACTIVE;
    end

    // Bank occupancy, bank pointers, completion counter and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bst[0]     <= EMPTY;
            bst[1]     <= EMPTY;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            tiles_done <= '0;
            err_access <= 1'b0;
        end else begin
            if (p_take) bst[wr_ptr] <= WRITING;
            if (p_rel) begin
                bst[wr_ptr] <= FULL;
                wr_ptr      <= ~wr_ptr;
            end
            if (c_take) bst[rd_ptr] <= READING;
            if (c_rel) begin
                bst[rd_ptr] <= EMPTY;
                rd_ptr      <= ~rd_ptr;
                tiles_done  <= tiles_done + 16'd1;
            end
            if (err_now) err_access <= 1'b1;
        end
    end

    // Route producer writes and consumer read addresses to the owned bank only
    always_comb begin
        bank0_we     = bus.prod_we & p_grant & ~wr_ptr;
        bank1_we     = bus.prod_we & p_grant & wr_ptr;
        bank0_addr_a = (p_grant & ~wr_ptr) ? bus.prod_addr : '0;
        bank1_addr_a = (p_grant & wr_ptr) ? bus.prod_addr : '0;
        bank0_din_a  = (p_grant & ~wr_ptr) ? bus.prod_din : '0;
        bank1_din_a  = (p_grant & wr_ptr) ? bus.prod_din : '0;
        bank0_addr_b = (c_grant & ~rd_ptr) ? bus.cons_addr : '0;
        bank1_addr_b = (c_grant & rd_ptr) ? bus.cons_addr : '0;
        bank_full    = {bst[1] == FULL, bst[0] == FULL};
    end

    // Read pipeline tracks each honoured read and its bank until the bank data
    // emerges, so reads in flight at cons_done still complete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr   <= '0;
            sel_sr   <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
        end else begin
            vld_sr[0] <= bus.cons_re & c_grant;
            sel_sr[0] <= rd_ptr;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                sel_sr[i] <= sel_sr[i-1];
            end
            dvalid_q <= vld_sr[RD_LAT-1];
            if (vld_sr[RD_LAT-1]) dout_q <= sel_sr[RD_LAT-1] ? bank1_dout_b : bank0_dout_b;
        end
    end

    assign bus.prod_grant  = p_grant;
    assign bus.prod_bank   = p_grant & wr_ptr;
    assign bus.cons_grant  = c_grant;
    assign bus.cons_bank   = c_grant & rd_ptr;
    assign bus.cons_dout   = dout_q;
    assign bus.cons_dvalid = dvalid_q;
endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// tb_pingpong_buf_ctrl: directed self-checking bench for the ping-pong buffer controller
module tb_pingpong_buf_ctrl;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              bank0_we, bank1_we;
    logic [ADDR_W-1:0] bank0_addr_a, bank1_addr_a, bank0_addr_b, bank1_addr_b;
    logic [DATA_W-1:0] bank0_din_a, bank1_din_a;
    logic [DATA_W-1:0] bank0_dout_b = '0;
    logic [DATA_W-1:0] bank1_dout_b = '0;
    logic [1:0]        bank_full;
    logic [15:0]       tiles_done;
    logic              err_access;
    int                n_vec = 0;
    int                n_err = 0;

    pingpong_buf_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    pingpong_buf_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .bank0_we     (bank0_we),
        .bank1_we     (bank1_we),
        .bank0_addr_a (bank0_addr_a),
        .bank1_addr_a (bank1_addr_a),
        .bank0_din_a  (bank0_din_a),
        .bank1_din_a  (bank1_din_a),
        .bank0_addr_b (bank0_addr_b),
        .bank1_addr_b (bank1_addr_b),
        .bank0_dout_b (bank0_dout_b),
        .bank1_dout_b (bank1_dout_b),
        .bank_full    (bank_full),
        .tiles_done   (tiles_done),
        .err_access   (err_access)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        next();
        next();
        rst_n = 1'b1;
    endtask

    task automatic fill_tile();
        bus.prod_start = 1'b1;
        next();
        bus.prod_start = 1'b0;
        bus.prod_done  = 1'b1;
        next();
        bus.prod_done  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.prod_start = 1'b0;
        bus.prod_we    = 1'b0;
        bus.prod_addr  = '0;
        bus.prod_din   = '0;
        bus.prod_done  = 1'b0;
        bus.cons_start = 1'b0;
        bus.cons_re    = 1'b0;
        bus.cons_addr  = '0;
        bus.cons_done  = 1'b0;
        repeat (3) next();
        settle();
        check("rst_prod_grant", bus.prod_grant, 0);
        check("rst_cons_grant", bus.cons_grant, 0);
        check("rst_bank_full", bank_full, 0);
        check("rst_tiles", tiles_done, 0);
        check("rst_err", err_access, 0);
        check("rst_dvalid", bus.cons_dvalid, 0);
        check("rst_dout", bus.cons_dout, 0);
        check("rst_we", {bank0_we, bank1_we}, 0);
        next();
        rst_n = 1'b1;
        // producer grant and write routing
        next();
        bus.prod_start = 1'b1;
        next();
        bus.prod_start = 1'b0;
        bus.prod_we    = 1'b1;
        bus.prod_addr  = 12'd5;
        bus.prod_din   = 64'hA5;
        settle();
        check("p1_grant", bus.prod_grant, 1);
        check("p1_bank", bus.prod_bank, 0);
        check("p1_we0", bank0_we, 1);
        check("p1_addr0", bank0_addr_a, 5);
        check("p1_din0", bank0_din_a, 64'hA5);
        check("p1_we1", bank1_we, 0);
        check("p1_addr1", bank1_addr_a, 0);
        next();
        bus.prod_we   = 1'b0;
        bus.prod_done = 1'b1;
        next();
        bus.prod_done  = 1'b0;
        bus.cons_start = 1'b1;
        settle();
        check("p1_drop", bus.prod_grant, 0);
        check("p1_full", bank_full, 2'b01);
        // consumer grant and read latency
        next();
        bus.cons_start = 1'b0;
        bus.cons_re    = 1'b1;
        bus.cons_addr  = 12'd5;
        bank0_dout_b   = 64'hA5;
        bank1_dout_b   = 64'h5A;
        settle();
        check("c1_grant", bus.cons_grant, 1);
        check("c1_bank", bus.cons_bank, 0);
        check("c1_addr0", bank0_addr_b, 5);
        check("c1_addr1", bank1_addr_b, 0);
        check("c1_full", bank_full, 0);
        next();
        bus.cons_re = 1'b0;
        settle();
        check("c1_dv_early", bus.cons_dvalid, 0);
        next();
        settle();
        check("c1_dv", bus.cons_dvalid, 1);
        check("c1_dout", bus.cons_dout, 64'hA5);
        next();
        bus.cons_done = 1'b1;
        settle();
        check("c1_dv_late", bus.cons_dvalid, 0);
        next();
        bus.cons_done = 1'b0;
        settle();
        check("c1_drop", bus.cons_grant, 0);
        check("c1_tiles", tiles_done, 1);
        // both banks full, producer stalls until bank0 is consumed
        do_reset();
        fill_tile();
        fill_tile();
        settle();
        check("s_full", bank_full, 2'b11);
        bus.prod_start = 1'b1;
        next();
        settle();
        check("s_stall1", bus.prod_grant, 0);
        next();
        settle();
        check("s_stall2", bus.prod_grant, 0);
        bus.cons_start = 1'b1;
        next();
        bus.cons_start = 1'b0;
        settle();
        check("s_cgrant", bus.cons_grant, 1);
        check("s_cbank", bus.cons_bank, 0);
        check("s_stall3", bus.prod_grant, 0);
        bus.cons_done = 1'b1;
        next();
        bus.cons_done = 1'b0;
        settle();
        check("s_gap", bus.prod_grant, 0);
        check("s_cdrop", bus.cons_grant, 0);
        check("s_full2", bank_full, 2'b10);
        next();
        bus.prod_start = 1'b0;
        settle();
        check("s_pgrant", bus.prod_grant, 1);
        check("s_pbank", bus.prod_bank, 0);
        check("s_tiles", tiles_done, 1);
        // simultaneous completions on different banks
        bus.cons_start = 1'b1;
        next();
        bus.cons_start = 1'b0;
        settle();
        check("d_cgrant", bus.cons_grant, 1);
        check("d_cbank", bus.cons_bank, 1);
        bus.prod_done = 1'b1;
        bus.cons_done = 1'b1;
        next();
        bus.prod_done = 1'b0;
        bus.cons_done = 1'b0;
        settle();
        check("d_full", bank_full, 2'b01);
        check("d_tiles", tiles_done, 2);
        check("d_pdrop", bus.prod_grant, 0);
        check("d_cdrop", bus.cons_grant, 0);
        check("d_err", err_access, 0);
        // read strobe without grant
        bus.cons_re   = 1'b1;
        bus.cons_addr = 12'd7;
        settle();
        check("e_addr0", bank0_addr_b, 0);
        check("e_addr1", bank1_addr_b, 0);
        next();
        bus.cons_re = 1'b0;
        settle();
        check("e_err", err_access, 1);
        check("e_dv1", bus.cons_dvalid, 0);
        next();
        settle();
        check("e_dv2", bus.cons_dvalid, 0);
        check("e_sticky", err_access, 1);
        check("e_full", bank_full, 2'b01);
        // reset in the middle of a bank1 write
        bus.prod_start = 1'b1;
        next();
        bus.prod_start = 1'b0;
        bus.prod_we    = 1'b1;
        bus.prod_addr  = 12'd9;
        bus.prod_din   = 64'h1234;
        settle();
        check("r_grant", bus.prod_grant, 1);
        check("r_bank", bus.prod_bank, 1);
        check("r_we1", bank1_we, 1);
        check("r_addr1", bank1_addr_a, 9);
        rst_n = 1'b0;
        #1;
        check("r_async_grant", bus.prod_grant, 0);
        check("r_async_we1", bank1_we, 0);
        check("r_async_addr1", bank1_addr_a, 0);
        check("r_async_full", bank_full, 0);
        check("r_async_err", err_access, 0);
        check("r_async_tiles", tiles_done, 0);
        bus.prod_we = 1'b0;
        next();
        next();
        rst_n = 1'b1;
        bus.prod_start = 1'b1;
        next();
        bus.prod_start = 1'b0;
        settle();
        check("r_regrant", bus.prod_grant, 1);
        check("r_rebank", bus.prod_bank, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
